// File: rtl/pcm_mm_arbiter_if.sv
// Bus bundle between the CPU cluster, the PCM arbiter and the single-ported PCM RAM.
// The arbiter takes the slave view; the CPU/memory environment takes the master view.
interface pcm_mm_arbiter_if #(
   parameter int N_CPU  = 4,
   parameter int ADDR_W = 20,
   parameter int MEM_AW = 11,
   parameter int DATA_W = 16
);
   localparam int BE_W = DATA_W / 8;

   logic [N_CPU-1:0]        cpu_req;
   logic [N_CPU-1:0]        cpu_write;
   logic [N_CPU*ADDR_W-1:0] cpu_addr;
   logic [N_CPU*DATA_W-1:0] cpu_wdata;
   logic [N_CPU*BE_W-1:0]   cpu_be;
   logic [N_CPU-1:0]        cpu_ready;
   logic [N_CPU-1:0]        cpu_err;
   logic [N_CPU*DATA_W-1:0] cpu_rdata;

   logic [MEM_AW-1:0]       mem_address;
   logic                    mem_chipselect;
   logic                    mem_clken;
   logic                    mem_write;
   logic [DATA_W-1:0]       mem_writedata;
   logic [BE_W-1:0]         mem_byteenable;
   logic [DATA_W-1:0]       mem_readdata;

   modport slave (
      input  cpu_req, cpu_write, cpu_addr, cpu_wdata, cpu_be, mem_readdata,
      output cpu_ready, cpu_err, cpu_rdata,
      output mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata, mem_byteenable
   );

   modport master (
      output cpu_req, cpu_write, cpu_addr, cpu_wdata, cpu_be, mem_readdata,
      input  cpu_ready, cpu_err, cpu_rdata,
      input  mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata, mem_byteenable
   );
endinterface

// File: rtl/pcm_mm_arbiter.sv
// N-channel arbiter onto one single-ported PCM RAM: fixed-priority or round-robin grant,
// one transaction in flight, out-of-range detection and per-channel held read data.
module pcm_mm_arbiter #(
   parameter int N_CPU   = 4,
   parameter int ADDR_W  = 20,
   parameter int MEM_AW  = 11,
   parameter int DATA_W  = 16,
   parameter int RD_LAT  = 1,
   parameter int RR_MODE = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            init,
   pcm_mm_arbiter_if.slave bus
);
   localparam int IDX_W = (N_CPU > 1) ? $clog2(N_CPU) : 1;
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = 2;

   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;

   state_t            state, state_nx;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  win;
   logic [IDX_W-1:0]  grant_idx;
   logic [IDX_W-1:0]  cand;
   logic              grant_vld;
   logic [ADDR_W-1:0] g_addr;
   logic              lat_wr;
   logic              lat_ok;
   logic [MEM_AW-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [BE_W-1:0]   lat_be;
   logic [CNT_W-1:0]  wait_cnt;
   logic              rd_last;
   logic [DATA_W-1:0] rdata_q [N_CPU];

   // Candidate examined at search step k: rotated past the last winner in round-robin mode.
   function automatic logic [IDX_W-1:0] rot(input int k, input logic [IDX_W-1:0] ptr);
      int idx;
      idx = (RR_MODE != 0) ? (int'(ptr) + 1 + k) % N_CPU : k;
      return IDX_W'(idx);
   endfunction

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < N_CPU; k++) begin
         cand = rot(k, rr_ptr);
         if (!grant_vld && bus.cpu_req[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign g_addr  = bus.cpu_addr[grant_idx*ADDR_W +: ADDR_W];
   assign rd_last = (state == RDWAIT) && (wait_cnt == CNT_W'(RD_LAT - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx           = state;
      bus.mem_chipselect = 1'b0;
      bus.mem_write      = 1'b0;
      bus.cpu_ready      = '0;
      bus.cpu_err        = '0;
      case (state)
         IDLE:   if (grant_vld) state_nx = ISSUE;
         ISSUE: begin
            bus.mem_chipselect = lat_ok;
            bus.mem_write      = lat_ok && lat_wr;
            state_nx           = (lat_ok && !lat_wr) ? RDWAIT : DONE;
         end
         RDWAIT: if (rd_last) state_nx = DONE;
         DONE: begin
            bus.cpu_ready[win] = 1'b1;
            bus.cpu_err[win]   = !lat_ok;
            state_nx           = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (init) state_nx = IDLE;
   end

   // Grant-time snapshot; the CPU side may change its request as soon as ready is seen.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr    <= IDX_W'(N_CPU - 1);
         win       <= '0;
         lat_wr    <= 1'b0;
         lat_ok    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         wait_cnt  <= '0;
      end else if (init) begin
         rr_ptr <= IDX_W'(N_CPU - 1);
      end else begin
         if (state == IDLE && grant_vld) begin
            win       <= grant_idx;
            if (RR_MODE != 0) rr_ptr <= grant_idx;
            lat_wr    <= bus.cpu_write[grant_idx];
            lat_ok    <= ((g_addr >> MEM_AW) == '0);
            lat_addr  <= g_addr[MEM_AW-1:0];
            lat_wdata <= bus.cpu_wdata[grant_idx*DATA_W +: DATA_W];
            lat_be    <= bus.cpu_write[grant_idx] ? bus.cpu_be[grant_idx*BE_W +: BE_W] : '1;
         end
         if (state == ISSUE)       wait_cnt <= '0;
         else if (state == RDWAIT) wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // NOTE: the held read-data array must come out of reset as zero, so it is built from resettable flops rather than a RAM macro.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_CPU; i++) rdata_q[i] <= '0;
      end else if (rd_last && !init) begin
         rdata_q[win] <= bus.mem_readdata;
      end
   end

   for (genvar g = 0; g < N_CPU; g++) begin : g_rdata
      assign bus.cpu_rdata[g*DATA_W +: DATA_W] = rdata_q[g];
   end

   assign bus.mem_clken      = 1'b1;
   assign bus.mem_address    = lat_addr;
   assign bus.mem_writedata  = lat_wdata;
   assign bus.mem_byteenable = lat_be;
endmodule

// File: doc/pcm_mm_arbiter.md
# pcm_mm_arbiter

Parametrised N-channel arbiter connecting several CPU request ports to one single-ported PCM memory over a memory-mapped (address/chipselect/clken/write/byteenable) interface. Successor to the fixed four-CPU PCM memory scheduler: adds configurable channel count, widths and read latency, selectable fixed-priority or round-robin arbitration, per-channel byte enables, and out-of-range address detection. Sits between the CPU cluster and the on-chip PCM RAM.

## Interface
- N_CPU, 4: number of CPU channels (2..8)
- ADDR_W, 20: CPU address width
- MEM_AW, 11: memory address width (MEM_AW <= ADDR_W)
- DATA_W, 16: data width (multiple of 8)
- RD_LAT, 1: memory read latency in cycles (1..3)
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority (channel 0 highest)
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- init  in  1  synchronous clear: aborts the current transaction, state to IDLE, RR pointer to reset value
- cpu_req  in  N_CPU  per-channel request level
- cpu_write  in  N_CPU  1 = write, 0 = read
- cpu_addr  in  N_CPU*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- cpu_wdata  in  N_CPU*DATA_W  packed write data
- cpu_be  in  N_CPU*DATA_W/8  packed write byte enables
- cpu_ready  out  N_CPU  one-cycle completion pulse
- cpu_err  out  N_CPU  one-cycle error pulse, coincident with cpu_ready
- cpu_rdata  out  N_CPU*DATA_W  per-channel read data, held until the next read on that channel completes
- mem_address  out  MEM_AW  memory address
- mem_chipselect  out  1  high during the ISSUE cycle only
- mem_clken  out  1  constant 1
- mem_write  out  1  high during ISSUE of a valid write
- mem_writedata  out  DATA_W  write data
- mem_byteenable  out  DATA_W/8  cpu_be for writes, all ones for reads
- mem_readdata  in  DATA_W  memory read data, valid RD_LAT cycles after the ISSUE cycle

## Operation
- Reset values: all outputs 0 except mem_clken = 1; state IDLE; RR pointer = N_CPU-1, so channel 0 is first in line; all cpu_rdata = 0.
- States: IDLE -> ISSUE -> (read: RDWAIT for RD_LAT cycles) -> DONE -> IDLE. A write goes ISSUE -> DONE.
- IDLE: if any cpu_req bit is high, select a winner.
  - Fixed priority: the lowest index wins.
  - Round-robin: search starts at pointer+1 and wraps modulo N_CPU. The pointer is updated to the winner at grant.
- At grant, the winner's write, address, wdata and be are latched. Memory outputs are driven from this latched copy.
- Range check: if addr[ADDR_W-1:MEM_AW] != 0, the request is out of range.
  - mem_chipselect and mem_write stay 0.
  - The FSM still passes through ISSUE and DONE (no RDWAIT).
  - cpu_err pulses with cpu_ready.
  - cpu_rdata is not updated.
- Read: mem_readdata is captured into cpu_rdata[winner] on the last RDWAIT cycle edge.
- DONE: cpu_ready[winner] pulses for one cycle. The CPU holds req, addr and data stable from assertion until it sees ready. If req is still high in the cycle after ready, that is a new request.
- Non-granted requests wait without loss. No starvation in round-robin mode.
- init is high: return to IDLE next edge; no ready pulse for the aborted transaction; RR pointer reset; cpu_rdata retained.
- reset_n low mid-transaction: immediate return to reset values; the transaction is dropped.

## Timing
- Request high in cycle 0 while IDLE: grant at the end of cycle 0; ISSUE is cycle 1.
- Write: cpu_ready in cycle 2. The throughput is one write per 3 cycles.
- Read: data captured at the end of cycle 1+RD_LAT; cpu_ready and the valid cpu_rdata in cycle 2+RD_LAT.
- Out of range: cpu_ready and cpu_err in cycle 2.
- Back-to-back arbitration resumes in the IDLE cycle after DONE.

## Test plan
- Single write then read, channel 2, addr 0x00123, data 0xBEEF, be 2'b11: write ready in cycle 2; with RD_LAT=2, read ready in cycle 4 with cpu_rdata[2] = 0xBEEF.
- Byte enable: write 0xFFFF then 0x1234 with be 2'b01: readback returns 0xFF34.
- Round-robin with all 4 req held high and reads: grant order 0,1,2,3,0. With RR_MODE=0 and all held high, channel 0 is granted every transaction.
- Out of range: addr 0x00800 (bit 11 set), write: no mem_chipselect; cpu_ready[1] and cpu_err[1] in cycle 2; memory is unchanged.
- init pulsed during RDWAIT: no cpu_ready; the FSM is IDLE in the next cycle; the next grant goes to channel 0.
- reset_n low during ISSUE: all outputs return to reset values asynchronously; after release, a pending request completes normally.
